writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage between the memory stage and the register file.
- Latches one retiring instruction per cycle in a MEM/WB register and selects the result: ALU, aligned/extended load data, or PC+4.
- Drives the register-file write port (write_en, rd_addr, rd_data) and a forwarding copy for the decode stage.
- Keeps a retired-instruction counter and a sticky load-misalignment flag.

Parameters:
XLEN, 32, datapath width
ADDR, 5, register index width (2**ADDR architectural registers)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  memory stage presents a retiring instruction
in_ready  out  1  stage accepts the beat this cycle
flush  in  1  drop the incoming beat and invalidate the MEM/WB register
hold  in  1  stall: accept nothing this cycle
in_reg_write  in  1  instruction writes rd
in_rd_addr  in  ADDR  destination register
in_wb_sel  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
in_alu_result  in  XLEN  ALU result
in_mem_rdata  in  XLEN  raw word read from data memory
in_funct3  in  3  load type
in_addr_lsb  in  2  byte offset of the load address
in_pc_plus4  in  XLEN  link value
rf_write_en  out  1  register-file write strobe
rf_rd_addr  out  ADDR  register-file write index
rf_rd_data  out  XLEN  register-file write data
fwd_valid  out  1  forwarding copy of rf_write_en
fwd_rd_addr  out  ADDR  forwarding index
fwd_data  out  XLEN  forwarding data
retire_count  out  32  instructions retired
misalign_err  out  1  sticky load-fault flag
err_clear  in  1  clears misalign_err

Behaviour:
- Reset (rst=1 at clock edge): MEM/WB register invalid with all fields 0; retire_count=0; misalign_err=0. All rf_*/fwd_* outputs are 0. in_ready=0 while rst is high.
- Handshake:
  - in_ready = !rst && !hold.
  - Beat captured when in_valid && in_ready && !flush.
  - Otherwise the MEM/WB register becomes invalid (bubble) at the next edge.
  - No backpressure from the register file.
- Latency: beat captured at edge N. Outputs are valid combinationally from the MEM/WB register during cycle N..N+1. The register file writes at edge N+1. Each entry is presented for exactly one cycle; hold never duplicates a write.
- Result select and load formatting (computed before capture, stored in MEM/WB):
  - LB (000) / LBU (100): byte in_mem_rdata[8*lsb+:8], sign- or zero-extended.
  - LH (001) / LHU (101): halfword at lsb[1], sign- or zero-extended.
  - LW (010): full word.
- Load faults:
  - Misaligned: LH/LHU with lsb[0]=1, or LW with lsb≠0.
  - Illegal funct3 (011, 110, 111) with wb_sel=01.
  - Either condition marks the entry faulted.
- rf_write_en = valid && reg_write && rd_addr≠0 && !faulted. Writes to x0 are suppressed here, not only in the register file. rf_rd_addr and rf_rd_data always reflect the register contents, even when the strobe is 0.
- fwd_* are identical to rf_* in every cycle.
- retire_count increments by 1 for each valid, non-faulted entry, including rd=0 and reg_write=0 entries. Wraps from 0xFFFFFFFF to 0.
- misalign_err is set at the capture edge of a faulted beat. err_clear clears it at the next edge. If a new fault and err_clear occur in the same cycle, set wins.
- flush and in_valid in the same cycle: the beat is dropped, not counted, and the MEM/WB register becomes invalid.
- rst asserted mid-stream: the in-flight entry is discarded with no write. Counter and flag return to 0.

Test Plan:
- Reset, then ALU beat rd=5, alu=0xDEADBEEF, reg_write=1 -> next cycle rf_write_en=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF, fwd identical; retire_count=1.
- Load mem_rdata=0x80F17F01: LB lsb=3 -> 0xFFFFFF80; LBU lsb=3 -> 0x00000080; LH lsb=2 -> 0xFFFF80F1; LHU lsb=0 -> 0x00007F01; LW lsb=0 -> 0x80F17F01.
- LW with lsb=2, rd=7 -> rf_write_en=0; misalign_err=1 and stays 1; retire_count unchanged. Then err_clear=1 alongside a new LH lsb=1 fault -> misalign_err remains 1. err_clear alone -> 0.
- rd=0 with reg_write=1, wb_sel=10 -> rf_write_en=0, retire_count+1. Also JAL-type beat rd=1, pc_plus4=0x104 -> rf_rd_data=0x104.
- in_valid held for 3 cycles with hold=1 in cycle 2 -> in_ready=0 in cycle 2; exactly 2 writes. flush=1 with in_valid=1 -> no write, no count.
- Preload retire_count to 0xFFFFFFFF via 2^32-1 beats (or a force), one more beat -> 0. rst asserted with a valid entry -> no write that cycle, all outputs 0.

Source files
------------

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage. Latches one retiring instruction per
//               cycle in the MEM/WB register, formats load data, selects the
//               write-back result and drives the register-file write port plus
//               a forwarding copy. Tracks retired instructions and a sticky
//               load-fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int XLEN = 32,
  parameter int ADDR = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            hold,
  input  logic            in_reg_write,
  input  logic [ADDR-1:0] in_rd_addr,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lsb,
  input  logic [XLEN-1:0] in_pc_plus4,
  output logic            rf_write_en,
  output logic [ADDR-1:0] rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            fwd_valid,
  output logic [ADDR-1:0] fwd_rd_addr,
  output logic [XLEN-1:0] fwd_data,
  output logic [31:0]     retire_count,
  output logic            misalign_err,
  input  logic            err_clear
);

  localparam logic [1:0] c_wb_load = 2'b01;
  localparam logic [1:0] c_wb_link = 2'b10;

  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;

  // MEM/WB register and bookkeeping state
  logic            valid_q,     valid_d;
  logic            reg_write_q, reg_write_d;
  logic [ADDR-1:0] rd_addr_q,   rd_addr_d;
  logic [XLEN-1:0] data_q,      data_d;
  logic            faulted_q,   faulted_d;
  logic [31:0]     retire_q,    retire_d;
  logic            misalign_q,  misalign_d;

  logic            w_capture;
  logic            w_fault;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_result;
  logic            w_write;

  assign in_ready  = !rst && !hold;
  assign w_capture = in_valid && in_ready && !flush;

  assign w_byte = in_mem_rdata[{in_addr_lsb, 3'b000} +: 8];
  assign w_half = in_addr_lsb[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];

  // Load alignment / extension and fault detection for the incoming beat
  always_comb begin
    w_load_data = '0;
    w_fault     = 1'b0;
    case (in_funct3)
      c_f3_lb:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_f3_lbu: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      c_f3_lh: begin
        w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
        w_fault     = in_addr_lsb[0];
      end
      c_f3_lhu: begin
        w_load_data = {{(XLEN-16){1'b0}}, w_half};
        w_fault     = in_addr_lsb[0];
      end
      c_f3_lw: begin
        w_load_data = in_mem_rdata;
        w_fault     = (in_addr_lsb != 2'b00);
      end
      default:  w_fault = 1'b1;  // funct3 011/110/111 are not loads
    endcase
    // Faults only matter when the result actually comes from memory
    if (in_wb_sel != c_wb_load) begin
      w_fault = 1'b0;
    end
  end

  // Result select; the reserved encoding 11 falls back to the ALU result
  always_comb begin
    case (in_wb_sel)
      c_wb_load: w_result = w_load_data;
      c_wb_link: w_result = in_pc_plus4;
      default:   w_result = in_alu_result;
    endcase
  end

  // Next-state for MEM/WB register, retire counter and sticky fault flag
  always_comb begin
    valid_d     = 1'b0;
    reg_write_d = reg_write_q;
    rd_addr_d   = rd_addr_q;
    data_d      = data_q;
    faulted_d   = faulted_q;
    retire_d    = retire_q;
    misalign_d  = misalign_q;
    if (err_clear) begin
      misalign_d = 1'b0;
    end
    if (w_capture) begin
      valid_d     = 1'b1;
      reg_write_d = in_reg_write;
      rd_addr_d   = in_rd_addr;
      data_d      = w_result;
      faulted_d   = w_fault;
      if (w_fault) begin
        misalign_d = 1'b1;        // a new fault beats a same-cycle clear
      end else begin
        retire_d = retire_q + 32'd1;
      end
    end
  end

  // State update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      data_q      <= '0;
      faulted_q   <= 1'b0;
      retire_q    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      data_q      <= data_d;
      faulted_q   <= faulted_d;
      retire_q    <= retire_d;
      misalign_q  <= misalign_d;
    end
  end

  // rst gates the outputs so an in-flight entry never reaches the register file
  assign w_write     = valid_q && reg_write_q && (rd_addr_q != '0) && !faulted_q && !rst;
  assign rf_write_en = w_write;
  assign rf_rd_addr  = rst ? '0 : rd_addr_q;
  assign rf_rd_data  = rst ? '0 : data_q;

  assign fwd_valid   = rf_write_en;
  assign fwd_rd_addr = rf_rd_addr;
  assign fwd_data    = rf_rd_data;

  assign retire_count = retire_q;
  assign misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, hold, in_reg_write, err_clear;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel, in_addr_lsb;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;
  logic [2:0]  in_funct3;
  logic        rf_write_en, fwd_valid, misalign_err;
  logic [4:0]  rf_rd_addr, fwd_rd_addr;
  logic [31:0] rf_rd_data, fwd_data, retire_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .ADDR(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .hold(hold), .in_reg_write(in_reg_write),
    .in_rd_addr(in_rd_addr), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_funct3(in_funct3), .in_addr_lsb(in_addr_lsb),
    .in_pc_plus4(in_pc_plus4), .rf_write_en(rf_write_en),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
    .retire_count(retire_count), .misalign_err(misalign_err),
    .err_clear(err_clear)
  );

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] pc);
    in_valid = 1'b1; in_reg_write = rw; in_rd_addr = rd; in_wb_sel = sel;
    in_alu_result = alu; in_mem_rdata = rdata; in_funct3 = f3;
    in_addr_lsb = lsb; in_pc_plus4 = pc;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_reg_write = 1'b0; in_rd_addr = '0; in_wb_sel = '0;
    in_alu_result = '0; in_mem_rdata = '0; in_funct3 = '0;
    in_addr_lsb = '0; in_pc_plus4 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; hold = 1'b0; err_clear = 1'b0;
    idle();
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b want 0", in_ready); end
    n_cmp++; if (rf_write_en !== 1'b0 || fwd_valid !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0b/%0b want 0/0", rf_write_en, fwd_valid); end
    n_cmp++; if (rf_rd_data !== 32'h0 || rf_rd_addr !== 5'd0 || fwd_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h/%0d/%h want 0", rf_rd_data, rf_rd_addr, fwd_data); end
    n_cmp++; if (retire_count !== 32'h0 || misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_state: got cnt=%h err=%0b want 0/0", retire_count, misalign_err); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %0b want 1", in_ready); end
    exp_cnt = 32'd0;
  endtask

  task automatic test_alu();
    drive(1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 3'b000, 2'b00, 32'h0);
    tick();
    idle();
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (rf_write_en !== 1'b1 || rf_rd_addr !== 5'd5 || rf_rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_rf: got we=%0b rd=%0d d=%h want 1/5/deadbeef", rf_write_en, rf_rd_addr, rf_rd_data); end
    n_cmp++; if (fwd_valid !== 1'b1 || fwd_rd_addr !== 5'd5 || fwd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_fwd: got v=%0b rd=%0d d=%h want 1/5/deadbeef", fwd_valid, fwd_rd_addr, fwd_data); end
    n_cmp++; if (retire_count !== 32'd1) begin n_err++; $display("FAIL alu_count: got %0d want 1", retire_count); end
    tick();
    n_cmp++; if (rf_write_en !== 1'b0) begin n_err++; $display("FAIL alu_single_cycle: got we=%0b want 0", rf_write_en); end
    // reserved select 11 behaves as ALU
    drive(1'b1, 5'd6, 2'b11, 32'h12345678, 32'hFFFFFFFF, 3'b000, 2'b00, 32'h44);
    tick();
    idle();
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (rf_write_en !== 1'b1 || rf_rd_data !== 32'h12345678) begin n_err++; $display("FAIL sel11_alu: got we=%0b d=%h want 1/12345678", rf_write_en, rf_rd_data); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001};
    logic [1:0]  lsb_t [7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [31:0] exp_t [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F01,
                               32'h80F17F01, 32'h0000007F, 32'h00007F01};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 5'(10 + i), 2'b01, 32'hAAAAAAAA, 32'h80F17F01, f3_t[i], lsb_t[i], 32'h0);
      tick();
      exp_cnt = exp_cnt + 1;
      n_cmp++; if (rf_write_en !== 1'b1 || rf_rd_addr !== 5'(10 + i) || rf_rd_data !== exp_t[i]) begin n_err++; $display("FAIL load_%0d: got we=%0b rd=%0d d=%h want 1/%0d/%h", i, rf_write_en, rf_rd_addr, rf_rd_data, 10 + i, exp_t[i]); end
    end
    idle();
    n_cmp++; if (retire_count !== exp_cnt || misalign_err !== 1'b0) begin n_err++; $display("FAIL load_count: got cnt=%0d err=%0b want %0d/0", retire_count, misalign_err, exp_cnt); end
    tick();
  endtask

  task automatic test_faults();
    drive(1'b1, 5'd7, 2'b01, 32'h0, 32'h11223344, 3'b010, 2'd2, 32'h0);
    tick();
    idle();
    n_cmp++; if (rf_write_en !== 1'b0 || misalign_err !== 1'b1 || retire_count !== exp_cnt) begin n_err++; $display("FAIL lw_misalign: got we=%0b err=%0b cnt=%0d want 0/1/%0d", rf_write_en, misalign_err, retire_count, exp_cnt); end
    tick(); tick();
    n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %0b want 1", misalign_err); end
    drive(1'b1, 5'd8, 2'b01, 32'h0, 32'h11223344, 3'b001, 2'd1, 32'h0);
    err_clear = 1'b1;
    tick();
    idle();
    err_clear = 1'b0;
    n_cmp++; if (misalign_err !== 1'b1 || rf_write_en !== 1'b0) begin n_err++; $display("FAIL set_beats_clear: got err=%0b we=%0b want 1/0", misalign_err, rf_write_en); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %0b want 0", misalign_err); end
    // illegal funct3 with load select
    drive(1'b1, 5'd9, 2'b01, 32'h0, 32'h11223344, 3'b110, 2'd0, 32'h0);
    tick();
    idle();
    n_cmp++; if (misalign_err !== 1'b1 || rf_write_en !== 1'b0 || retire_count !== exp_cnt) begin n_err++; $display("FAIL illegal_f3: got err=%0b we=%0b cnt=%0d want 1/0/%0d", misalign_err, rf_write_en, retire_count, exp_cnt); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic test_x0_link();
    drive(1'b1, 5'd0, 2'b10, 32'h0, 32'h0, 3'b000, 2'd0, 32'h200);
    tick();
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (rf_write_en !== 1'b0 || fwd_valid !== 1'b0 || retire_count !== exp_cnt) begin n_err++; $display("FAIL x0_write: got we=%0b fv=%0b cnt=%0d want 0/0/%0d", rf_write_en, fwd_valid, retire_count, exp_cnt); end
    drive(1'b1, 5'd1, 2'b10, 32'h55, 32'h0, 3'b000, 2'd0, 32'h104);
    tick();
    idle();
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (rf_write_en !== 1'b1 || rf_rd_addr !== 5'd1 || rf_rd_data !== 32'h104 || fwd_data !== 32'h104) begin n_err++; $display("FAIL jal_link: got we=%0b rd=%0d d=%h want 1/1/104", rf_write_en, rf_rd_addr, rf_rd_data); end
    // reg_write=0 still retires
    drive(1'b0, 5'd3, 2'b00, 32'h9, 32'h0, 3'b000, 2'd0, 32'h0);
    tick();
    idle();
    exp_cnt = exp_cnt + 1;
    n_cmp++; if (rf_write_en !== 1'b0 || retire_count !== exp_cnt) begin n_err++; $display("FAIL no_rw: got we=%0b cnt=%0d want 0/%0d", rf_write_en, retire_count, exp_cnt); end
    tick();
  endtask

  task automatic test_hold_flush();
    int writes = 0;
    drive(1'b1, 5'd20, 2'b00, 32'hA1, 32'h0, 3'b000, 2'd0, 32'h0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_c1_ready: got %0b want 1", in_ready); end
    tick();
    if (rf_write_en === 1'b1) writes++;
    drive(1'b1, 5'd21, 2'b00, 32'hB2, 32'h0, 3'b000, 2'd0, 32'h0);
    hold = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_c2_ready: got %0b want 0", in_ready); end
    tick();
    if (rf_write_en === 1'b1) writes++;
    hold = 1'b0;
    tick();
    if (rf_write_en === 1'b1) writes++;
    n_cmp++; if (rf_rd_addr !== 5'd21 || rf_rd_data !== 32'hB2) begin n_err++; $display("FAIL hold_c3_data: got rd=%0d d=%h want 21/b2", rf_rd_addr, rf_rd_data); end
    idle();
    tick();
    if (rf_write_en === 1'b1) writes++;
    exp_cnt = exp_cnt + 2;
    n_cmp++; if (writes != 2 || retire_count !== exp_cnt) begin n_err++; $display("FAIL hold_writes: got writes=%0d cnt=%0d want 2/%0d", writes, retire_count, exp_cnt); end
    // valid entry followed by a flushed beat
    drive(1'b1, 5'd22, 2'b00, 32'hC3, 32'h0, 3'b000, 2'd0, 32'h0);
    tick();
    exp_cnt = exp_cnt + 1;
    drive(1'b1, 5'd23, 2'b00, 32'hD4, 32'h0, 3'b000, 2'd0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    n_cmp++; if (rf_write_en !== 1'b0 || retire_count !== exp_cnt) begin n_err++; $display("FAIL flush: got we=%0b cnt=%0d want 0/%0d", rf_write_en, retire_count, exp_cnt); end
  endtask

  task automatic test_wrap_and_rst();
    force dut.retire_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_q;
    #1;
    n_cmp++; if (retire_count !== 32'hFFFFFFFF) begin n_err++; $display("FAIL preload: got %h want ffffffff", retire_count); end
    drive(1'b1, 5'd4, 2'b00, 32'h77, 32'h0, 3'b000, 2'd0, 32'h0);
    tick();
    idle();
    n_cmp++; if (retire_count !== 32'h0 || rf_write_en !== 1'b1) begin n_err++; $display("FAIL wrap: got cnt=%h we=%0b want 0/1", retire_count, rf_write_en); end
    // set the flag, then assert rst while a valid entry is presented
    drive(1'b1, 5'd9, 2'b01, 32'h0, 32'h0, 3'b111, 2'd0, 32'h0);
    tick();
    drive(1'b1, 5'd12, 2'b00, 32'h99, 32'h0, 3'b000, 2'd0, 32'h0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    n_cmp++; if (rf_write_en !== 1'b0 || fwd_valid !== 1'b0 || rf_rd_data !== 32'h0 || rf_rd_addr !== 5'd0) begin n_err++; $display("FAIL rst_mid_out: got we=%0b fv=%0b d=%h rd=%0d want 0", rf_write_en, fwd_valid, rf_rd_data, rf_rd_addr); end
    tick();
    n_cmp++; if (retire_count !== 32'h0 || misalign_err !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_state: got cnt=%h err=%0b rdy=%0b want 0/0/0", retire_count, misalign_err, in_ready); end
    rst = 1'b0;
    tick();
    n_cmp++; if (rf_write_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_after: got we=%0b want 0", rf_write_en); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_faults();
    test_x0_link();
    test_hold_flush();
    test_wrap_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
